// File: rtl/simple_cpu_core.sv
// simple_cpu_core: three-state (IDLE/EXEC/WB) accumulator-style CPU core with
// a small register file, a small data memory and an optional flags register.
// Ports:
//   clk, rst                  - rising-edge clock, asynchronous active-high reset
//   instruction, instr_valid  - instruction word {op, rd, imm} and its valid
//   instr_ready               - high only in IDLE; accept = instr_valid && instr_ready
//   done                      - one-cycle pulse in the cycle after WB (retirement)
//   alu_result_debug          - registered result of the last executed instruction
//   reg0_debug, reg1_debug    - live contents of R0 / R1
//   flags                     - {carry, zero}, only when PROC_FLAGS_EN is defined
// Optional feature macro: PROC_FLAGS_EN (adds the flags port and flag logic).
// Timing: accept on edge E0, EXEC->WB on E1 (ALU result, memory write),
// WB->IDLE on E2 (register write, done raised); next accept no earlier than E3.

module simple_cpu_core #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 2,
  parameter int MEM_AW = 4,
  localparam int INSTR_W = 4 + REG_AW + DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic               done,
  output logic [DATA_W-1:0]  alu_result_debug,
  output logic [DATA_W-1:0]  reg0_debug,
  output logic [DATA_W-1:0]  reg1_debug
`ifdef PROC_FLAGS_EN
  ,
  output logic [1:0]         flags
`endif
);

  localparam int NREG = 2 ** REG_AW;
  localparam int NMEM = 2 ** MEM_AW;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_LD  = 4'b0110;
  localparam logic [3:0] OP_ST  = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t state;
  state_t next_state;
  logic   accept;

  // Architectural state
  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] mem  [NMEM];
  logic [DATA_W-1:0] result_q;

  // Instruction / operand latches, captured on accept
  logic [3:0]        op_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] a_q;   // R[rd] at accept
  logic [DATA_W-1:0] b_q;   // R[rs] at accept
  logic [MEM_AW-1:0] addr_q;

  // Field decode of the incoming word
  logic [3:0]        dec_op;
  logic [REG_AW-1:0] dec_rd;
  logic [REG_AW-1:0] dec_rs;
  logic [DATA_W-1:0] dec_imm;

  assign dec_op  = instruction[INSTR_W-1 -: 4];
  assign dec_rd  = instruction[DATA_W +: REG_AW];
  assign dec_imm = instruction[DATA_W-1:0];
  assign dec_rs  = dec_imm[REG_AW-1:0];

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    instr_ready = 1'b0;
    accept      = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          accept     = 1'b1;
          next_state = S_EXEC;
        end
      end
      S_EXEC:  next_state = S_WB;
      S_WB:    next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand capture: operands are read when leaving IDLE, so rd == rs is safe
  // and a result written in WB is visible to the next accepted instruction.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      rd_q  <= '0;
      imm_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (accept) begin
      op_q  <= dec_op;
      rd_q  <= dec_rd;
      imm_q <= dec_imm;
      a_q   <= regs[dec_rd];
      b_q   <= regs[dec_rs];
    end
  end

  // ---------------------------------------------------------------------------
  // ALU (evaluated during EXEC)
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] alu_res;
  logic              res_upd;   // result register takes alu_res at end of EXEC

  always_comb begin
    alu_res = '0;
    res_upd = 1'b1;
    case (op_q)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_NOT:  alu_res = ~b_q;
      OP_ST:   alu_res = b_q;
      OP_LDI:  alu_res = imm_q;
      // LD takes its result from memory in WB; 1001-1111 are NOPs.
      default: res_upd = 1'b0;
    endcase
  end

  // Register-file write enable for the instruction in WB
  logic wb_reg_en;
  always_comb begin
    wb_reg_en = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LD, OP_LDI: wb_reg_en = 1'b1;
      default: wb_reg_en = 1'b0;
    endcase
  end

  logic [DATA_W-1:0] wb_data;
  assign wb_data = (op_q == OP_LD) ? mem[addr_q] : result_q;

  // ---------------------------------------------------------------------------
  // Result register and memory address issue
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
    end else if (state == S_EXEC && res_upd) begin
      result_q <= alu_res;
    end else if (state == S_WB && op_q == OP_LD) begin
      result_q <= mem[addr_q];
    end
  end

  // LD address comes from R[rs]; upper bits beyond MEM_AW are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
    end else if (state == S_EXEC) begin
      addr_q <= b_q[MEM_AW-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Data memory: ST writes on the EXEC->WB edge, so an LD accepted afterwards
  // (earliest read is its own WB) always observes the stored word.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NMEM; i++) begin
        mem[i] <= '0;
      end
    end else if (state == S_EXEC && op_q == OP_ST) begin
      mem[a_q[MEM_AW-1:0]] <= b_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file: written on the WB->IDLE edge
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (state == S_WB && wb_reg_en) begin
      regs[rd_q] <= wb_data;
    end
  end

  // Retirement pulse, raised together with the register write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= (state == S_WB);
    end
  end

  assign alu_result_debug = result_q;
  assign reg0_debug       = regs[0];
  assign reg1_debug       = regs[1];

`ifdef PROC_FLAGS_EN
  // ---------------------------------------------------------------------------
  // Flags {carry, zero}: updated at the end of EXEC for ALU ops and LDI only.
  // ADD carry is detected as wrap-around of the truncated sum; SUB carry is
  // the borrow (rd < rs).
  // ---------------------------------------------------------------------------
  logic       flag_upd;
  logic       carry_nxt;
  logic [1:0] flags_q;

  always_comb begin
    flag_upd  = 1'b0;
    carry_nxt = 1'b0;
    case (op_q)
      OP_ADD: begin
        flag_upd  = 1'b1;
        carry_nxt = (alu_res < a_q);
      end
      OP_SUB: begin
        flag_upd  = 1'b1;
        carry_nxt = (a_q < b_q);
      end
      OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LDI: flag_upd = 1'b1;
      default: flag_upd = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 2'b00;
    end else if (state == S_EXEC && flag_upd) begin
      flags_q <= {carry_nxt, (alu_res == '0)};
    end
  end

  assign flags = flags_q;
`endif

endmodule

// File: tb/tb_simple_cpu_core.sv
// Testbench for simple_cpu_core (default parameters). A behavioural model
// applies each instruction's architectural effect at retirement; a compare
// process checks the DUT against it every cycle, and directed sequences add
// hand-computed literal expectations.

module tb_simple_cpu_core;

  logic        clk;
  logic        rst;
  logic [13:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic        done;
  logic [7:0]  alu_result_debug;
  logic [7:0]  reg0_debug;
  logic [7:0]  reg1_debug;
`ifdef PROC_FLAGS_EN
  logic [1:0]  flags;
`endif

  simple_cpu_core dut (
    .clk              (clk),
    .rst              (rst),
    .instruction      (instruction),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .done             (done),
    .alu_result_debug (alu_result_debug),
    .reg0_debug       (reg0_debug),
`ifdef PROC_FLAGS_EN
    .flags            (flags),
`endif
    .reg1_debug       (reg1_debug)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  bit run   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [13:0] mk(input int op, input int rd, input int imm);
    logic [3:0] o;
    logic [1:0] d;
    logic [7:0] i;
    o = op[3:0];
    d = rd[1:0];
    i = imm[7:0];
    return {o, d, i};
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model: an accepted instruction retires two clock edges later;
  // its whole architectural effect is applied at that point.
  // ---------------------------------------------------------------------------
  logic [7:0]  m_reg [4];
  logic [7:0]  m_mem [16];
  logic [7:0]  m_res;
  logic        m_c;
  logic        m_z;
  logic        m_done;
  int          m_stage = 0;
  logic [13:0] m_instr;

  task automatic alu_wr(input logic [1:0] rd, input int val, input logic c);
    logic [7:0] v;
    v = val[7:0];
    m_reg[rd] = v;
    m_res     = v;
    m_c       = c;
    m_z       = (v == 8'h00);
  endtask

  task automatic retire(input logic [13:0] w);
    int op, a, b, imm;
    logic [1:0] rd, rs;
    logic [7:0] av, bv;
    op  = int'(w[13:10]);
    rd  = w[9:8];
    imm = int'(w[7:0]);
    rs  = w[1:0];
    av  = m_reg[rd];
    bv  = m_reg[rs];
    a   = int'(av);
    b   = int'(bv);
    case (op)
      0: alu_wr(rd, (a + b) % 256, (a + b) > 255);
      1: alu_wr(rd, (a - b + 256) % 256, a < b);
      2: alu_wr(rd, a & b, 1'b0);
      3: alu_wr(rd, a | b, 1'b0);
      4: alu_wr(rd, a ^ b, 1'b0);
      5: alu_wr(rd, 255 - b, 1'b0);
      6: begin
        m_reg[rd] = m_mem[b % 16];
        m_res     = m_mem[b % 16];
      end
      7: begin
        m_mem[a % 16] = bv;
        m_res         = bv;
      end
      8: alu_wr(rd, imm, 1'b0);
      default: ;
    endcase
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_res   = 8'h00;
        m_c     = 1'b0;
        m_z     = 1'b0;
        m_done  = 1'b0;
        m_stage = 0;
      end else begin
        m_done = 1'b0;
        if (m_stage > 0) begin
          m_stage--;
          if (m_stage == 0) begin
            retire(m_instr);
            m_done = 1'b1;
          end
        end else if (instr_valid) begin
          m_instr = instruction;
          m_stage = 2;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (run && !rst) begin
      check("ready", {31'd0, instr_ready}, {31'd0, (m_stage == 0)});
      check("done", {31'd0, done}, {31'd0, m_done});
      check("reg0", {24'd0, reg0_debug}, {24'd0, m_reg[0]});
      check("reg1", {24'd0, reg1_debug}, {24'd0, m_reg[1]});
      if (m_stage == 0) begin
        check("alu", {24'd0, alu_result_debug}, {24'd0, m_res});
`ifdef PROC_FLAGS_EN
        check("flags", {30'd0, flags}, {30'd0, m_c, m_z});
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers (called at a negedge, return at a negedge)
  // ---------------------------------------------------------------------------
  task automatic send(input logic [13:0] w);
    int n;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) check("ready_timeout", {31'd0, instr_ready}, 32'd1);
    instruction = w;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  // Issue one instruction and count cycles from its accept edge to done.
  task automatic exec(input logic [13:0] w, output int lat);
    send(w);
    lat = 1;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_timeout", {31'd0, done}, 32'd1);
  endtask

  int  lat;
  int  low;
  bit  seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instruction = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_reg0", {24'd0, reg0_debug}, 32'h00);
    check("rst_reg1", {24'd0, reg1_debug}, 32'h00);
    check("rst_alu", {24'd0, alu_result_debug}, 32'h00);
    run = 1;

    // LDI / ADD with retirement latency
    exec(mk(8, 0, 8'h05), lat);
    check("ldi_lat", lat, 3);
    check("ldi_r0", {24'd0, reg0_debug}, 32'h05);
    exec(mk(8, 1, 8'h03), lat);
    check("ldi1_lat", lat, 3);
    exec(mk(0, 0, 1), lat);
    check("add_lat", lat, 3);
    check("add_r0", {24'd0, reg0_debug}, 32'h08);
    check("add_alu", {24'd0, alu_result_debug}, 32'h08);

    // SUB with borrow
    exec(mk(8, 0, 8'h02), lat);
    exec(mk(1, 0, 1), lat);
    check("sub_r0", {24'd0, reg0_debug}, 32'hFF);
    check("sub_alu", {24'd0, alu_result_debug}, 32'hFF);
`ifdef PROC_FLAGS_EN
    check("sub_flags", {30'd0, flags}, 32'd2);
`endif

    // ADD wrap-around, then rd == rs
    exec(mk(8, 1, 8'h01), lat);
    exec(mk(0, 0, 1), lat);
    check("addwrap_r0", {24'd0, reg0_debug}, 32'h00);
`ifdef PROC_FLAGS_EN
    check("addwrap_flags", {30'd0, flags}, 32'd3);
`endif
    exec(mk(8, 1, 8'h3C), lat);
    exec(mk(1, 1, 1), lat);
    check("subself_r1", {24'd0, reg1_debug}, 32'h00);

    // Logic ops: R0=0xF0, R1=0x3C
    exec(mk(8, 0, 8'hF0), lat);
    exec(mk(8, 1, 8'h3C), lat);
    exec(mk(4, 0, 1), lat);
    check("xor_r0", {24'd0, reg0_debug}, 32'hCC);
    exec(mk(5, 0, 1), lat);
    check("not_r0", {24'd0, reg0_debug}, 32'hC3);
    exec(mk(2, 1, 0), lat);
    check("and_r1", {24'd0, reg1_debug}, 32'h00);

    // Store then load, plus address wrap
    exec(mk(8, 0, 8'h0A), lat);
    exec(mk(8, 1, 8'h5C), lat);
    exec(mk(7, 0, 1), lat);
    check("st_alu", {24'd0, alu_result_debug}, 32'h5C);
    exec(mk(8, 1, 8'h00), lat);
    exec(mk(6, 1, 0), lat);
    check("ld_r1", {24'd0, reg1_debug}, 32'h5C);
    check("ld_alu", {24'd0, alu_result_debug}, 32'h5C);
    exec(mk(8, 0, 8'h1A), lat);
    exec(mk(8, 1, 8'h00), lat);
    exec(mk(6, 1, 0), lat);
    check("ld_wrap_r1", {24'd0, reg1_debug}, 32'h5C);

    // instr_valid held high with changing words during EXEC/WB
    low = 0;
    instruction = mk(8, 0, 8'h11);
    instr_valid = 1'b1;
    @(negedge clk);
    if (!instr_ready) low++;
    instruction = mk(8, 1, 8'h22);
    @(negedge clk);
    if (!instr_ready) low++;
    instruction = mk(8, 0, 8'h99);
    @(negedge clk);
    if (!instr_ready) low++;
    instruction = mk(8, 1, 8'h44);
    @(negedge clk);
    instruction = mk(8, 0, 8'hEE);
    @(negedge clk);
    instruction = mk(8, 1, 8'hDD);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("hold_ready_low", low, 2);
    check("hold_r0", {24'd0, reg0_debug}, 32'h11);
    check("hold_r1", {24'd0, reg1_debug}, 32'h44);

    // NOP (op 1111)
    exec(mk(8, 0, 8'h33), lat);
    exec(mk(15, 0, 8'hA5), lat);
    check("nop_lat", lat, 3);
    check("nop_r0", {24'd0, reg0_debug}, 32'h33);
    check("nop_alu", {24'd0, alu_result_debug}, 32'h33);

    // Reset during EXEC of LDI R0,0x77
    instruction = mk(8, 0, 8'h77);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", {31'd0, instr_ready}, 32'd1);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("midrst_nodone", {31'd0, seen}, 32'd0);
    check("midrst_r0", {24'd0, reg0_debug}, 32'h00);
    check("midrst_alu", {24'd0, alu_result_debug}, 32'h00);

    run = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simple_cpu_core.md
SIMPLE_CPU_CORE -- requirements
Module: simple_cpu_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning datapath/register/memory word width (>=4).
REQ-002 SHALL have parameter REG_AW, default 2, meaning register address width; register count = 2**REG_AW.
REQ-003 SHALL have parameter MEM_AW, default 4, meaning data memory address width; depth = 2**MEM_AW.
REQ-004 SHALL define INSTR_W = 4 + REG_AW + DATA_W, with instruction = {op[3:0], rd[REG_AW-1:0], imm[DATA_W-1:0]}; rs = imm[REG_AW-1:0].
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port instruction  input  INSTR_W  instruction word, sampled on accept.
REQ-008 SHALL have port instr_valid  input  1  instruction present.
REQ-009 SHALL have port instr_ready  output  1  core can accept an instruction.
REQ-010 SHALL have port done  output  1  one-cycle pulse at instruction retirement.
REQ-011 SHALL have port alu_result_debug  output  DATA_W  registered result of last executed instruction.
REQ-012 SHALL have ports reg0_debug / reg1_debug  output  DATA_W  live contents of R0 / R1.
REQ-013 SHALL have port flags  output  2  {carry, zero}; present only with PROC_FLAGS_EN.

Function
REQ-014 SHALL implement FSM IDLE -> EXEC -> WB -> IDLE; instr_ready = 1 only in IDLE.
REQ-015 SHALL accept when instr_valid && instr_ready, latching instruction and moving to EXEC; instr_valid in EXEC/WB SHALL be ignored.
REQ-016 SHALL in EXEC compute the ALU result into a result register and issue memory access; in WB write the register file, pulse done and return to IDLE.
REQ-017 SHALL retire every instruction exactly 3 cycles after its accept edge; back-to-back throughput 1 instruction per 3 cycles.
REQ-018 SHALL decode op: 0000 ADD rd=rd+rs; 0001 SUB rd=rd-rs; 0010 AND; 0011 OR; 0100 XOR; 0101 NOT rd=~rs; 0110 LD rd=mem[R[rs][MEM_AW-1:0]]; 0111 ST mem[R[rd][MEM_AW-1:0]]=R[rs]; 1000 LDI rd=imm.
REQ-019 SHALL treat ops 1001-1111 as NOP: no register/memory write, alu_result_debug unchanged, done still pulses in WB.
REQ-020 SHALL wrap arithmetic modulo 2**DATA_W; upper address bits beyond MEM_AW SHALL be ignored.
REQ-021 SHALL write memory on the EXEC->WB edge for ST; ST SHALL NOT write the register file; alu_result_debug for ST = stored data.
REQ-022 SHALL return the memory word for LD in WB, so an ST immediately followed by LD to the same address returns the new data.
REQ-023 SHALL read operands when leaving IDLE, so rd == rs is legal (e.g. SUB R1,R1 yields 0).

Reset
REQ-024 SHALL on rst, at any time including mid-instruction, force state IDLE, all registers, memory, alu_result_debug and flags to 0, done to 0; an in-flight instruction SHALL be discarded with no write.
REQ-025 SHALL assert instr_ready = 1 from the first cycle after rst deasserts.

Configuration
REQ-026 SHALL with macro PROC_FLAGS_EN defined provide port flags: zero = (result == 0), carry = ADD carry-out / SUB borrow (0 for logic ops), updated in EXEC only for ops 0000-0101 and 1000, held otherwise.
REQ-027 SHALL without PROC_FLAGS_EN omit port flags and all flag logic; all other behaviour identical.

Verification
REQ-028 SHALL cover: reset, LDI R0,0x05; LDI R1,0x03; ADD R0,R1 -> reg0_debug=0x08, done pulses 3 cycles after each accept.
REQ-029 SHALL cover: R0=0x02, R1=0x03, SUB R0,R1 -> R0=0xFF, alu_result_debug=0xFF, flags carry=1 zero=0 (with PROC_FLAGS_EN).
REQ-030 SHALL cover: R0=0x0A (addr), R1=0x5C, ST R0,R1 then LD R1,R0 after clearing R1 -> R1=0x5C.
REQ-031 SHALL cover: instr_valid held high with changing instruction during EXEC/WB -> only accepted words execute, instr_ready low for 2 cycles.
REQ-032 SHALL cover: rst asserted during EXEC of LDI R0,0x77 -> R0 remains 0x00, no done pulse, instr_ready=1 after release.
REQ-033 SHALL cover: op 1111 with R0=0x33 -> done pulses, R0 and alu_result_debug unchanged.
